// File: rtl/rv_core_seq.sv
// rv_core_seq: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB) with PC, instret and sticky traps.
module rv_core_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  output logic             ir_we_o,
  input  logic             dec_illegal_i,
  input  logic             dec_mem_rd_i,
  input  logic             dec_mem_wr_i,
  input  logic             dec_rf_we_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  output logic             rf_we_o,
  output logic [31:0]      pc_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [2:0]       state_o
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
  localparam int WC_W = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1);
  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d, tgt_q, tgt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             br_q, br_d, trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic             misal, tmo;
  assign misal = br_q && (tgt_q[1:0] != 2'b00);
  assign tmo   = (TIMEOUT != 0) && (wc_q == WC_W'(TIMEOUT));
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    br_d       = br_q;
    tgt_d      = tgt_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    case (state_q)
      IDLE:   state_d = run_i ? FETCH : IDLE;
      FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ack_i;
        if (imem_ack_i) state_d = DECODE;
        else if (tmo) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end
      end
      DECODE: begin
        state_d = dec_illegal_i ? TRAP : EXEC;
        trap_d  = trap_q | dec_illegal_i;
        cause_d = dec_illegal_i ? 2'd0 : cause_q;
      end
      EXEC: begin
        br_d    = br_taken_i;
        tgt_d   = br_target_i;
        state_d = (dec_mem_rd_i || dec_mem_wr_i) ? MEM : WB;
      end
      MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_mem_wr_i;
        if (dmem_ack_i) state_d = WB;
        else if (tmo) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd3;
        end
      end
      WB: begin
        if (misal) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else begin
          rf_we_o   = dec_rf_we_i;
          pc_d      = br_q ? tgt_q : pc_q + 32'd4;
          instret_d = instret_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
    // counter restarts on every state change, so entering FETCH/MEM always starts from zero
    wc_d = (state_d != state_q) ? '0 : (imem_req_o || dmem_req_o) ? wc_q + WC_W'(1) : wc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      br_q      <= 1'b0;
      tgt_q     <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      wc_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      br_q      <= br_d;
      tgt_q     <= tgt_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      wc_q      <= wc_d;
    end
  end
  assign pc_o         = pc_q;
  assign instret_o    = instret_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_rv_core_seq.sv
// tb_rv_core_seq: table-driven and directed checks of the rv_core_seq control sequencer.
module tb_rv_core_seq;
  logic        clk = 0, rst_n = 0, run = 0, iack = 0, ill = 0, rd = 0, wr = 0, rfwe = 0, brt = 0, dack = 0;
  logic [31:0] tgt = 0;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, trap;
  logic [31:0] pc, instret;
  logic [1:0]  cause;
  logic [2:0]  st;
  int          errs = 0, checks = 0;
  rv_core_seq dut (
    .clk(clk), .rst_n(rst_n), .run_i(run), .imem_req_o(imem_req), .imem_ack_i(iack), .ir_we_o(ir_we),
    .dec_illegal_i(ill), .dec_mem_rd_i(rd), .dec_mem_wr_i(wr), .dec_rf_we_i(rfwe), .br_taken_i(brt),
    .br_target_i(tgt), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ack_i(dack), .rf_we_o(rf_we),
    .pc_o(pc), .instret_o(instret), .trap_o(trap), .trap_cause_o(cause), .state_o(st)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] tgt;
    logic        dack;
    logic [2:0]  st;
    logic [4:0]  stb;
    logic [31:0] pc, ir;
  } vec_t;
  vec_t vq[$];
  task automatic av(input logic [6:0] ctl, input logic [31:0] t, input logic d, input logic [2:0] s,
                    input logic [4:0] stb, input logic [31:0] p, input logic [31:0] n);
    vec_t v;
    v.ctl = ctl; v.tgt = t; v.dack = d; v.st = s; v.stb = stb; v.pc = p; v.ir = n;
    vq.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic do_reset;
    rst_n = 0; run = 0; iack = 0; ill = 0; rd = 0; wr = 0; rfwe = 0; brt = 0; dack = 0; tgt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic start;
    @(negedge clk); run = 1;
    @(negedge clk); run = 0;
  endtask
  // called in a FETCH cycle; returns in the cycle after EXEC (MEM or WB)
  task automatic to_exec(input logic r, input logic w, input logic f, input logic b, input logic [31:0] t);
    iack = 1; rd = r; wr = w; rfwe = f;
    @(negedge clk); iack = 0;
    @(negedge clk); brt = b; tgt = t;
    @(negedge clk); brt = 0; tgt = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, k;
    // ctl = {run, imem_ack, illegal, mem_rd, mem_wr, rf_we, br_taken}; stb = {imem_req, ir_we, dmem_req, dmem_we, rf_we}
    av(7'b0000000, 0, 0, 0, 5'b00000, 0, 0);
    av(7'b1000000, 0, 0, 0, 5'b00000, 0, 0);
    av(7'b0100010, 0, 0, 1, 5'b11000, 0, 0);
    av(7'b0000010, 0, 0, 2, 5'b00000, 0, 0);
    av(7'b0000010, 0, 0, 3, 5'b00000, 0, 0);
    av(7'b0000010, 0, 0, 5, 5'b00001, 0, 0);
    av(7'b0100000, 0, 0, 1, 5'b11000, 4, 1);
    av(7'b0000000, 0, 0, 2, 5'b00000, 4, 1);
    av(7'b0000001, 32'h100, 0, 3, 5'b00000, 4, 1);
    av(7'b0000000, 0, 0, 5, 5'b00000, 4, 1);
    av(7'b0101010, 0, 0, 1, 5'b11000, 32'h100, 2);
    av(7'b0001010, 0, 0, 2, 5'b00000, 32'h100, 2);
    av(7'b0001010, 0, 0, 3, 5'b00000, 32'h100, 2);
    av(7'b0001010, 0, 0, 4, 5'b00100, 32'h100, 2);
    av(7'b0001010, 0, 0, 4, 5'b00100, 32'h100, 2);
    av(7'b0001010, 0, 0, 4, 5'b00100, 32'h100, 2);
    av(7'b0001010, 0, 1, 4, 5'b00100, 32'h100, 2);
    av(7'b0001010, 0, 0, 5, 5'b00001, 32'h100, 2);
    av(7'b0100100, 0, 0, 1, 5'b11000, 32'h104, 3);
    av(7'b0000100, 0, 0, 2, 5'b00000, 32'h104, 3);
    av(7'b0000100, 0, 0, 3, 5'b00000, 32'h104, 3);
    av(7'b0000100, 0, 1, 4, 5'b00110, 32'h104, 3);
    av(7'b0000100, 0, 0, 5, 5'b00000, 32'h104, 3);
    av(7'b0000000, 0, 0, 1, 5'b10000, 32'h108, 4);
    av(7'b0100000, 0, 0, 1, 5'b11000, 32'h108, 4);
    av(7'b0000000, 0, 0, 2, 5'b00000, 32'h108, 4);
    do_reset;
    #1;
    chk("reset_state", st, 0);
    chk("reset_pc", pc, 0);
    chk("reset_imem_req", imem_req, 0);
    foreach (vq[i]) begin
      @(negedge clk);
      {run, iack, ill, rd, wr, rfwe, brt} = vq[i].ctl;
      tgt = vq[i].tgt; dack = vq[i].dack;
      #1;
      chk($sformatf("v%0d_state", i), st, vq[i].st);
      chk($sformatf("v%0d_strobes", i), {imem_req, ir_we, dmem_req, dmem_we, rf_we}, vq[i].stb);
      chk($sformatf("v%0d_pc", i), pc, vq[i].pc);
      chk($sformatf("v%0d_instret", i), instret, vq[i].ir);
      chk($sformatf("v%0d_trap", i), trap, 0);
    end
    // misaligned JAL target traps in WB, sticky until reset
    do_reset; start;
    to_exec(0, 0, 1, 1, 32'h102);
    #1;
    chk("jal_wb_state", st, 5);
    chk("jal_wb_rf_we", rf_we, 0);
    @(negedge clk); run = 1; iack = 1; #1;
    chk("jal_trap_state", st, 6);
    chk("jal_trap", trap, 1);
    chk("jal_cause", cause, 1);
    chk("jal_pc", pc, 0);
    chk("jal_instret", instret, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      chk("jal_sticky", {st, trap, imem_req, rf_we}, {3'd6, 3'b100});
    end
    // imem timeout after TIMEOUT+1 request cycles
    do_reset; start;
    n = 0; k = 0;
    while (st == 3'd1 && k < 40) begin
      #1; if (imem_req) n++;
      @(negedge clk); k++;
    end
    chk("ifetch_to_cycles", n, 17);
    chk("ifetch_to_state", st, 6);
    chk("ifetch_to_cause", {trap, cause}, 3'b110);
    // dmem ack on the last allowed cycle is accepted, then a real dmem timeout
    do_reset; start;
    to_exec(1, 0, 1, 0, 0);
    repeat (16) @(negedge clk);
    dack = 1; #1;
    chk("mem_late_req", {st, dmem_req}, {3'd4, 1'b1});
    @(negedge clk); dack = 0; #1;
    chk("mem_late_wb", {st, trap, rf_we}, {3'd5, 2'b01});
    @(negedge clk); #1;
    chk("mem_late_pc", pc, 4);
    chk("mem_late_instret", instret, 1);
    to_exec(1, 0, 1, 0, 0);
    n = 0; k = 0;
    while (st == 3'd4 && k < 40) begin
      #1; if (dmem_req) n++;
      @(negedge clk); k++;
    end
    chk("dmem_to_cycles", n, 17);
    chk("dmem_to_state", st, 6);
    chk("dmem_to_cause", {trap, cause}, 3'b111);
    chk("dmem_to_pc", pc, 4);
    // asynchronous reset in the middle of MEM
    do_reset; start;
    to_exec(0, 0, 1, 0, 0);
    @(negedge clk);
    to_exec(1, 0, 1, 0, 0);
    #1;
    chk("rst_mid_pre", {st, dmem_req}, {3'd4, 1'b1});
    chk("rst_mid_pre_pc", pc, 4);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_dmem_req", dmem_req, 0);
    chk("rst_mid_state", st, 0);
    chk("rst_mid_pc", pc, 0);
    chk("rst_mid_instret", instret, 0);
    @(negedge clk); rst_n = 1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
